// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs request fields into a 32-bit word, flags
// illegal types or out-of-range immediates, and buffers results in a 2-entry FIFO.
module instr_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_type,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] word_cnt
);

    typedef struct packed {
        logic        err;
        logic [31:0] instr;
    } entry_t;

    function automatic entry_t encode(
        input logic [3:0]        ty,
        input logic [4:0]        rd,
        input logic [4:0]        rs1,
        input logic [4:0]        rs2,
        input logic [2:0]        f3,
        input logic [6:0]        f7,
        input logic signed [31:0] imm
    );
        entry_t e;
        logic   imm12_ok;
        logic   imm13_ok;
        logic   imm21_ok;
        // An immediate fits when every bit above its sign bit copies the sign.
        imm12_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
        imm13_ok = (imm[31:12] == '0) || (imm[31:12] == '1);
        imm21_ok = (imm[31:20] == '0) || (imm[31:20] == '1);
        e.err   = 1'b0;
        e.instr = '0;
        case (ty)
            4'd0: e.instr = {f7, rs2, rs1, f3, rd, 7'b0110011};
            4'd1: begin
                e.instr = {imm[11:0], rs1, f3, rd, 7'b0010011};
                e.err   = !imm12_ok;
            end
            4'd2: begin
                e.instr = {imm[11:0], rs1, f3, rd, 7'b0000011};
                e.err   = !imm12_ok;
            end
            4'd3: begin
                e.instr = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
                e.err   = !imm12_ok;
            end
            4'd4: begin
                e.instr = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
                e.err   = !imm13_ok || imm[0];
            end
            4'd5: begin
                e.instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
                e.err   = !imm21_ok || imm[0];
            end
            4'd6: begin
                e.instr = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
                e.err   = !imm12_ok;
            end
            4'd7: begin
                e.instr = {imm[31:12], rd, 7'b0110111};
                e.err   = (imm[11:0] != '0);
            end
            4'd8: begin
                e.instr = {imm[31:12], rd, 7'b0010111};
                e.err   = (imm[11:0] != '0);
            end
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    entry_t          enc;
    entry_t          slot0;
    entry_t          slot1;
    logic [1:0]      count;
    logic            ready_en;
    logic            sticky;
    logic [CNT_W-1:0] cnt;
    logic            push;
    logic            pop;

    assign enc = encode(in_type, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);

    assign in_ready   = ready_en && (count != 2'd2) && !clr;
    assign out_valid  = (count != 2'd0);
    assign out_instr  = slot0.instr;
    assign out_err    = slot0.err;
    assign err_sticky = sticky;
    assign word_cnt   = cnt;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // FIFO stage: slot0 is always the head, slot1 the tail when two are held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0    <= '0;
            slot1    <= '0;
            count    <= 2'd0;
            ready_en <= 1'b0;
            sticky   <= 1'b0;
            cnt      <= '0;
        end else begin
            ready_en <= 1'b1;
            if (clr) begin
                count  <= 2'd0;
                sticky <= 1'b0;
                cnt    <= '0;
            end else begin
                if (pop) begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (push && enc.err) begin
                    sticky <= 1'b1;
                end
                case ({push, pop})
                    2'b11: slot0 <= enc;
                    2'b01: begin
                        slot0 <= slot1;
                        count <= count - 2'd1;
                    end
                    2'b10: begin
                        if (count == 2'd0) begin
                            slot0 <= enc;
                        end else begin
                            slot1 <= enc;
                        end
                        count <= count + 2'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: arithmetic reference model with queue-based FIFO,
// per-cycle comparison, directed literal vectors and randomized traffic.
module tb_instr_encoder;

    localparam int CNT_W = 4;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       in_type = '0;
    logic [4:0]       in_rd = '0;
    logic [4:0]       in_rs1 = '0;
    logic [4:0]       in_rs2 = '0;
    logic [2:0]       in_funct3 = '0;
    logic [6:0]       in_funct7 = '0;
    logic [31:0]      in_imm = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_instr;
    logic             out_err;
    logic             err_sticky;
    logic [CNT_W-1:0] word_cnt;

    instr_encoder #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_type(in_type), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err),
        .err_sticky(err_sticky), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: opcode table plus numeric range rules for immediates.
    logic [31:0] opc_tab [9] = '{32'h33, 32'h13, 32'h03, 32'h23, 32'h63,
                                 32'h6F, 32'h67, 32'h37, 32'h17};

    function automatic logic [32:0] ref_encode(
        input logic [3:0] t, input logic [4:0] rd, input logic [4:0] rs1,
        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
        input logic [31:0] imm
    );
        logic [31:0] w, r, s1, s2, fn3, fn7;
        longint      v;
        bit          err;
        r = 32'(rd); s1 = 32'(rs1); s2 = 32'(rs2); fn3 = 32'(f3); fn7 = 32'(f7);
        v = longint'($signed(imm));
        err = 1'b0;
        if (t > 4'd8) return {1'b1, 32'h0};
        w = opc_tab[t];
        case (t)
            4'd0: w = w | (r << 7) | (fn3 << 12) | (s1 << 15) | (s2 << 20) | (fn7 << 25);
            4'd1, 4'd2, 4'd6: begin
                w = w | (r << 7) | (((t == 4'd6) ? 32'h0 : fn3) << 12) | (s1 << 15)
                      | ((imm & 32'hFFF) << 20);
                err = (v < -2048) || (v > 2047);
            end
            4'd3: begin
                w = w | ((imm & 32'h1F) << 7) | (fn3 << 12) | (s1 << 15) | (s2 << 20)
                      | (((imm >> 5) & 32'h7F) << 25);
                err = (v < -2048) || (v > 2047);
            end
            4'd4: begin
                w = w | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8)
                      | (fn3 << 12) | (s1 << 15) | (s2 << 20)
                      | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'h1) << 31);
                err = (v < -4096) || (v > 4095) || (imm[0] == 1'b1);
            end
            4'd5: begin
                w = w | (r << 7) | (((imm >> 12) & 32'hFF) << 12) | (((imm >> 11) & 32'h1) << 20)
                      | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 20) & 32'h1) << 31);
                err = (v < -(64'sd1 << 20)) || (v >= (64'sd1 << 20)) || (imm[0] == 1'b1);
            end
            default: begin
                w = w | (r << 7) | (imm & 32'hFFFFF000);
                err = ((imm & 32'hFFF) != 0);
            end
        endcase
        return {err, w};
    endfunction

    logic [32:0] mq[$];
    int          m_cnt = 0;
    bit          m_sticky = 1'b0;
    bit          m_ren = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        bit          push, pop;
        logic [32:0] e;
        if (!rst_n) begin
            mq.delete();
            m_cnt = 0;
            m_sticky = 1'b0;
            m_ren = 1'b0;
        end else begin
            push = in_valid && m_ren && (mq.size() < 2) && !clr;
            pop  = (mq.size() > 0) && out_ready;
            e = ref_encode(in_type, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
            if (clr) begin
                mq.delete();
                m_cnt = 0;
                m_sticky = 1'b0;
            end else begin
                if (pop) begin
                    void'(mq.pop_front());
                    m_cnt = (m_cnt + 1) % CNT_MOD;
                end
                if (push) begin
                    mq.push_back(e);
                    if (e[32]) m_sticky = 1'b1;
                end
            end
            m_ren = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(m_ren && (mq.size() < 2) && !clr));
            chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
            chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
            if (mq.size() != 0) begin
                chk("out_instr", out_instr, mq[0][31:0]);
                chk("out_err", 32'(out_err), 32'(mq[0][32]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int t, input int rd, input int rs1, input int rs2,
                           input int f3, input int f7, input logic [31:0] imm);
        in_type = 4'(t); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
        in_funct3 = 3'(f3); in_funct7 = 7'(f7); in_imm = imm;
        in_valid = 1'b1;
    endtask

    task automatic set_rand_legal();
        set_req($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 31), $urandom_range(0, 7), 0,
                32'($urandom_range(0, 2047)));
    endtask

    // Push one request into an empty FIFO, check the head literally, then pop it.
    task automatic enc_lit(input string name, input int t, input int rd, input int rs1,
                           input int rs2, input int f3, input logic [31:0] imm,
                           input logic [31:0] exp_instr, input logic exp_err);
        out_ready = 1'b0;
        set_req(t, rd, rs1, rs2, f3, 0, imm);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk({name, "_instr"}, out_instr, exp_instr);
        chk({name, "_err"}, 32'(out_err), 32'(exp_err));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_err", 32'(out_err), 32'h0);
        chk("rst_err_sticky", 32'(err_sticky), 32'h0);
        chk("rst_word_cnt", 32'(word_cnt), 32'h0);
        #2 rst_n = 1'b1;
        #1 chk("ready_before_edge", 32'(in_ready), 32'h0);
        tick();
        chk("ready_after_edge", 32'(in_ready), 32'h1);

        enc_lit("opimm", 1, 1, 0, 0, 0, 32'd5, 32'h00500093, 1'b0);
        enc_lit("rtype", 0, 3, 1, 2, 0, 32'd0, 32'h002081B3, 1'b0);
        enc_lit("store", 3, 0, 1, 2, 2, 32'd8, 32'h0020A423, 1'b0);
        enc_lit("branch", 4, 0, 1, 2, 0, 32'd8, 32'h00208463, 1'b0);
        enc_lit("jal", 5, 1, 0, 0, 0, 32'd16, 32'h010000EF, 1'b0);
        enc_lit("lui", 7, 5, 0, 0, 0, 32'h12345000, 32'h123452B7, 1'b0);
        chk("sticky_clean", 32'(err_sticky), 32'h0);

        enc_lit("br_odd", 4, 0, 0, 0, 0, 32'd3, 32'h00000163, 1'b1);
        chk("sticky_set", 32'(err_sticky), 32'h1);
        enc_lit("bad_type", 12, 1, 2, 3, 1, 32'd0, 32'h00000000, 1'b1);
        enc_lit("opimm_big", 1, 0, 0, 0, 0, 32'd2048, 32'h80000013, 1'b1);

        // Backpressure: two accepts, third request stalls, then drain in order.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_sticky", 32'(err_sticky), 32'h0);
        out_ready = 1'b0;
        set_req(1, 1, 0, 0, 0, 0, 32'd5);
        tick();
        set_req(0, 3, 1, 2, 0, 0, 32'd0);
        tick();
        set_req(5, 1, 0, 0, 0, 0, 32'd16);
        @(negedge clk);
        chk("bp_ready_low", 32'(in_ready), 32'h0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_first", out_instr, 32'h00500093);
        tick();
        @(negedge clk);
        chk("bp_second", out_instr, 32'h002081B3);
        tick();
        @(negedge clk);
        chk("bp_word_cnt", 32'(word_cnt), 32'd2);
        chk("bp_empty", 32'(out_valid), 32'h0);

        // Wrap: 17 handshakes on a 4-bit counter, then clear with a full FIFO.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            set_rand_legal();
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("wrap_cnt", 32'(word_cnt), 32'd1);
        out_ready = 1'b0;
        set_rand_legal();
        tick();
        set_rand_legal();
        tick();
        in_valid = 1'b0;
        chk("full_ready", 32'(in_ready), 32'h0);
        chk("full_valid", 32'(out_valid), 32'h1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_valid", 32'(out_valid), 32'h0);
        chk("clr_cnt", 32'(word_cnt), 32'h0);

        // Streaming: one word per cycle for 100 cycles.
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            set_rand_legal();
            tick();
            chk("stream_valid", 32'(out_valid), 32'h1);
        end
        in_valid = 1'b0;
        chk("stream_cnt", 32'(word_cnt), 32'(99 % CNT_MOD));
        tick();
        chk("stream_drained", 32'(out_valid), 32'h0);

        // Reset with two words queued and a nonzero counter.
        out_ready = 1'b0;
        set_rand_legal();
        tick();
        set_rand_legal();
        tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_cnt", 32'(word_cnt), 32'h0);
        chk("mid_rst_ready", 32'(in_ready), 32'h0);
        chk("mid_rst_instr", out_instr, 32'h0);
        #3 rst_n = 1'b1;
        tick();
        tick();
        enc_lit("post_rst", 7, 5, 0, 0, 0, 32'h12345000, 32'h123452B7, 1'b0);

        // Randomized traffic, including illegal types, odd and out-of-range immediates.
        for (int i = 0; i < 400; i++) begin
            int          t;
            int          sel;
            logic [31:0] imm;
            t = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
            sel = $urandom_range(0, 3);
            case (sel)
                0: imm = $urandom;
                1: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                2: imm = (32'($urandom_range(0, 8191)) - 32'd4096) & 32'hFFFFFFFE;
                default: imm = $urandom & 32'hFFFFF000;
            endcase
            set_req(t, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                    $urandom_range(0, 7), $urandom_range(0, 127), imm);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 40) == 0);
            tick();
        end
        in_valid = 1'b0;
        clr = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("final_drained", 32'(out_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
